// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG sharing controller and its core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prng_pkg;

    // Sequencer phases: load seed, discard warm-up words, serve requesters.
    typedef enum logic [1:0] {
        ST_SEED = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Power-up seeds, also substituted when a runtime seed pair is all zero.
    localparam logic [31:0] DEF_SEED_S0 = 32'h0000_0001;
    localparam logic [31:0] DEF_SEED_S1 = 32'h0000_0002;

    // xoroshiro64* step constants.
    localparam int          XORO_ROT_A = 26;
    localparam int          XORO_SHIFT = 9;
    localparam int          XORO_ROT_B = 13;
    localparam logic [31:0] XORO_MULT  = 32'h9E37_79BB;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

endpackage

// File: rtl/prng_share_ctrl_core.sv
// xoroshiro64* generator: 2x32-bit state, registered 32-bit result, seed load.
// Latency: result updates one clock after a step (cg=1, seed_valid=0).
// Backpressure: none; cg=0 freezes state and result, so a word is held until consumed.
// Ports: clk; cg (step/load enable); seed_valid (load seeds instead of stepping);
//        seed_s0/seed_s1 (seed pair); result (registered output word).
// State has no reset: it is always reloaded by the controller before use.
module prng_share_ctrl_core
    import prng_pkg::*;
(
    input  logic        clk,
    input  logic        cg,
    input  logic        seed_valid,
    input  logic [31:0] seed_s0,
    input  logic [31:0] seed_s1,
    output logic [31:0] result
);

    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] mix;

    assign mix = s0 ^ s1;

    always_ff @(posedge clk) begin
        if (cg) begin
            if (seed_valid) begin
                s0 <= seed_s0;
                s1 <= seed_s1;
            end else begin
                // Output is scrambled from the pre-step s0.
                result <= s0 * XORO_MULT;
                s0     <= rotl32(s0, XORO_ROT_A) ^ mix ^ (mix << XORO_SHIFT);
                s1     <= rotl32(mix, XORO_ROT_B);
            end
        end
    end

endmodule

// File: rtl/prng_share_ctrl.sv
// Seeds one xoroshiro64* core, discards warm-up words, then round-robins words to requesters.
// Latency: grant is combinational; the granted word is o_data in the same cycle, next word at t+1.
// Backpressure: core only steps on a grant, so an unconsumed word is held between grants.
// Ports: i_clk, i_arstn (async active-low); i_reseed + i_seedS0/i_seedS1 (runtime reseed);
//        i_req (request levels); o_gnt (one-hot grant); o_data (word); o_ready (serving).
module prng_share_ctrl
    import prng_pkg::*;
#(
    parameter int          N_REQ   = 4,
    parameter int          WARMUP  = 8,
    parameter logic [31:0] SEED_S0 = DEF_SEED_S0,
    parameter logic [31:0] SEED_S1 = DEF_SEED_S1
) (
    input  logic             i_clk,
    input  logic             i_arstn,
    input  logic             i_reseed,
    input  logic [31:0]      i_seedS0,
    input  logic [31:0]      i_seedS1,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_gnt,
    output logic [31:0]      o_data,
    output logic             o_ready
);

    localparam int PTR_W = $clog2(N_REQ);
    // One extra code so the counter can pass WARMUP without wrapping.
    localparam int CNT_W = $clog2(WARMUP + 2);
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP);
    localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(N_REQ - 1);

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      hold_s0;
    logic [31:0]      hold_s1;
    logic [CNT_W-1:0] warm_cnt;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic             found;
    logic             cg;
    logic             seed_valid;

    // Round-robin pick: first requester above the pointer, else wrap to the
    // lowest index at or below it. Two passes give an explicit modulo-N_REQ
    // wrap that also holds for non-power-of-2 N_REQ.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && i_req[i] && (i > int'(ptr))) begin
                found = 1'b1;
                win   = PTR_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && i_req[i] && (i <= int'(ptr))) begin
                found = 1'b1;
                win   = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cg         = 1'b0;
        seed_valid = 1'b0;
        o_gnt      = '0;
        case (state)
            ST_SEED: begin
                seed_valid = 1'b1;
                cg         = 1'b1;
                state_nxt  = ST_WARM;
            end
            ST_WARM: begin
                // WARMUP+1 steps: the extra one flushes the stale result register.
                cg = 1'b1;
                if (warm_cnt == WARM_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (found) begin
                    o_gnt = {{(N_REQ-1){1'b0}}, 1'b1} << win;
                    cg    = 1'b1;
                end
            end
            default: state_nxt = ST_SEED;
        endcase
        // Reseed overrides everything; a SEED cycle still completes its load
        // (of the old holding regs), and the following SEED loads the new pair.
        if (i_reseed) begin
            state_nxt = ST_SEED;
            o_gnt     = '0;
            if (state != ST_SEED) begin
                cg = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state    <= ST_SEED;
            hold_s0  <= SEED_S0;
            hold_s1  <= SEED_S1;
            warm_cnt <= '0;
            ptr      <= PTR_RST;
        end else begin
            state <= state_nxt;
            if (i_reseed) begin
                // An all-zero state would lock the generator at zero forever.
                if ((i_seedS0 == 32'd0) && (i_seedS1 == 32'd0)) begin
                    hold_s0 <= SEED_S0;
                    hold_s1 <= SEED_S1;
                end else begin
                    hold_s0 <= i_seedS0;
                    hold_s1 <= i_seedS1;
                end
            end
            if (state == ST_SEED) begin
                warm_cnt <= '0;
            end else if (state == ST_WARM) begin
                warm_cnt <= warm_cnt + 1'b1;
            end
            if (|o_gnt) begin
                ptr <= win;
            end
        end
    end

    prng_share_ctrl_core u_core (
        .clk        (i_clk),
        .cg         (cg),
        .seed_valid (seed_valid),
        .seed_s0    (hold_s0),
        .seed_s1    (hold_s1),
        .result     (o_data)
    );

    assign o_ready = (state == ST_RUN);

endmodule
